// File: rtl/key_write_guard_pkg.sv
// Shared types and constants for the key-storage write guard and its policy checker.
package key_guard_pkg;
  typedef enum logic [1:0] {IDLE, CHECK, ISSUE, DENY} state_e;

  localparam int KEY_WORD_IDX   = 0;
  localparam int PROT_WORDS_DEF = 1;
  localparam int ADDR_W_DEF     = 32;
  localparam int DATA_W_DEF     = 32;
  localparam int VCNT_W_DEF     = 8;
endpackage

// File: rtl/key_write_guard_if.sv
// Request bus plus memory-side strobe and response, as seen by the guard (slave) and requester (master).
interface key_write_guard_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_we;
  logic [DATA_W-1:0] req_wd;
  logic [ADDR_W-1:0] address;
  logic              we;
  logic [DATA_W-1:0] wd;
  logic              rsp_valid;
  logic              rsp_err;

  modport slave (
    input  req_valid, req_addr, req_we, req_wd,
    output req_ready, address, we, wd, rsp_valid, rsp_err
  );

  modport master (
    output req_valid, req_addr, req_we, req_wd,
    input  req_ready, address, we, wd, rsp_valid, rsp_err
  );
endinterface

// File: rtl/key_write_guard_policy.sv
// Access policy: deny misaligned accesses and writes to protected words once locked.
module key_guard_policy
  import key_guard_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int PROT_WORDS = PROT_WORDS_DEF
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              we_i,
  input  logic              lock_eff_i,
  output logic              deny_o
);
  logic [ADDR_W-3:0] word_idx;
  logic              prot;
  logic              misaligned;

  always_comb begin
    word_idx   = addr_i[ADDR_W-1:2];
    prot       = (word_idx < (ADDR_W-2)'(PROT_WORDS));
    misaligned = (addr_i[1:0] != 2'b00);
    deny_o     = misaligned | (we_i & prot & lock_eff_i);
  end
endmodule

// File: rtl/key_write_guard.sv
// Gatekeeper in front of key storage: forwards requests, blocks locked key writes,
// and tracks violations for the security monitor.
module key_write_guard
  import key_guard_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int PROT_WORDS = PROT_WORDS_DEF,
  parameter int VCNT_W     = VCNT_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  key_write_guard_if.slave    bus,
  input  logic                lock_set,
  output logic                locked,
  output logic [VCNT_W-1:0]   viol_count,
  output logic                viol_sticky
);
  state_e            state_q;
  logic [ADDR_W-1:0] cap_addr_q;
  logic              cap_we_q;
  logic [DATA_W-1:0] cap_wd_q;
  logic              ready_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_we_q;
  logic [DATA_W-1:0] mem_wd_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic              locked_q;
  logic              locked_d;
  logic [VCNT_W-1:0] vcnt_q;
  logic [VCNT_W-1:0] vcnt_d;
  logic              sticky_q;
  logic              deny;

  // A lock pulse in the CHECK cycle already counts against the pending request.
  always_comb begin
    locked_d = locked_q | lock_set;
    vcnt_d   = (&vcnt_q) ? vcnt_q : vcnt_q + VCNT_W'(1);
  end

  key_guard_policy #(
    .ADDR_W     (ADDR_W),
    .PROT_WORDS (PROT_WORDS)
  ) u_policy (
    .addr_i     (cap_addr_q),
    .we_i       (cap_we_q),
    .lock_eff_i (locked_d),
    .deny_o     (deny)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cap_addr_q  <= '0;
      cap_we_q    <= 1'b0;
      cap_wd_q    <= '0;
      ready_q     <= 1'b1;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wd_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      locked_q    <= 1'b0;
      vcnt_q      <= '0;
      sticky_q    <= 1'b0;
    end else begin
      locked_q    <= locked_d;
      mem_we_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.req_valid && ready_q) begin
            cap_addr_q <= bus.req_addr;
            cap_we_q   <= bus.req_we;
            cap_wd_q   <= bus.req_wd;
            ready_q    <= 1'b0;
            state_q    <= CHECK;
          end
        end
        CHECK: state_q <= deny ? DENY : ISSUE;
        ISSUE: begin
          mem_addr_q  <= cap_addr_q;
          mem_we_q    <= cap_we_q;
          mem_wd_q    <= cap_wd_q;
          rsp_valid_q <= 1'b1;
          ready_q     <= 1'b1;
          state_q     <= IDLE;
        end
        DENY: begin
          // Memory address/data are left untouched so denied data never reaches storage.
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b1;
          vcnt_q      <= vcnt_d;
          sticky_q    <= 1'b1;
          ready_q     <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.address   = mem_addr_q;
  assign bus.we        = mem_we_q;
  assign bus.wd        = mem_wd_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign locked        = locked_q;
  assign viol_count    = vcnt_q;
  assign viol_sticky   = sticky_q;
endmodule

// File: tb/tb_key_write_guard.sv
// Randomized and directed checks of key_write_guard against a request-level reference model.
module tb_key_write_guard;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int PW = 1;
  localparam int VW = 8;
  localparam int VMAX = 255;

  logic          clk;
  logic          reset;
  logic          lock_set;
  logic          locked;
  logic [VW-1:0] viol_count;
  logic          viol_sticky;

  key_write_guard_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  key_write_guard #(
    .ADDR_W(AW), .DATA_W(DW), .PROT_WORDS(PW), .VCNT_W(VW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .lock_set    (lock_set),
    .locked      (locked),
    .viol_count  (viol_count),
    .viol_sticky (viol_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: state of the world as seen from outside the block.
  bit          m_locked;
  int          m_cnt;
  bit          m_sticky;
  logic [31:0] m_addr;
  logic [31:0] m_wd;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 0;
    m_cnt    = 0;
    m_sticky = 0;
    m_addr   = '0;
    m_wd     = '0;
  endtask

  task automatic check_status(input string ph);
    check({ph, "_locked"}, locked, m_locked);
    check({ph, "_viol_count"}, viol_count, m_cnt);
    check({ph, "_viol_sticky"}, viol_sticky, m_sticky);
    check({ph, "_address"}, bus.address, m_addr);
    check({ph, "_wd"}, bus.wd, m_wd);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    check("rst_req_ready", bus.req_ready, 1'b1);
    check("rst_we", bus.we, 1'b0);
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_rsp_err", bus.rsp_err, 1'b0);
    check_status("rst");
  endtask

  task automatic pulse_lock();
    @(negedge clk);
    lock_set = 1'b1;
    @(posedge clk);
    @(negedge clk);
    lock_set = 1'b0;
    m_locked = 1;
    check("lock_pulse_locked", locked, 1'b1);
  endtask

  // One request: accept, wait for the response, compare everything against the model.
  task automatic do_req(input logic [31:0] a, input logic w, input logic [31:0] d, input bit lock_mid);
    int  lat;
    bit  got;
    bit  m_deny;
    bit  prot;
    int  k;
    k = 0;
    while (!bus.req_ready && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("req_ready_idle", bus.req_ready, 1'b1);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_we    = w;
    bus.req_wd    = d;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom;
    bus.req_wd    = $urandom;
    check("req_ready_busy", bus.req_ready, 1'b0);
    if (lock_mid) lock_set = 1'b1;

    prot   = ((a >> 2) < PW);
    m_deny = (a[1:0] != 2'b00) || (w && prot && (m_locked || lock_mid));
    if (lock_mid) m_locked = 1;

    got = 0;
    lat = 0;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      lock_set = 1'b0;
      if (bus.rsp_valid === 1'b1) begin
        got = 1;
        lat = i;
        break;
      end
    end
    check("rsp_seen", got, 1'b1);
    check("rsp_latency", lat, 2);

    if (m_deny) begin
      if (m_cnt < VMAX) m_cnt++;
      m_sticky = 1;
    end else begin
      m_addr = a;
      m_wd   = d;
    end
    check("rsp_err", bus.rsp_err, m_deny);
    check("mem_we", bus.we, m_deny ? 1'b0 : w);
    check("resp_req_ready", bus.req_ready, 1'b1);
    check_status("resp");

    @(negedge clk);
    check("after_we", bus.we, 1'b0);
    check("after_rsp_valid", bus.rsp_valid, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout n_chk=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra;
    int          sel;
    reset         = 1'b1;
    lock_set      = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_we    = 1'b0;
    bus.req_wd    = '0;
    model_reset();

    do_reset();

    // Boot-time provisioning, then lock and try to overwrite the key.
    do_req(32'h0, 1'b1, 32'h1035_9987, 1'b0);
    pulse_lock();
    do_req(32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    do_req(32'h8, 1'b1, 32'h0000_0055, 1'b0);
    do_req(32'h0, 1'b0, 32'h1234_5678, 1'b0);
    do_req(32'h6, 1'b0, 32'h0, 1'b0);

    // Lock arriving in the CHECK cycle of a key write.
    do_reset();
    do_req(32'h0, 1'b1, 32'hCAFE_F00D, 1'b1);

    do_reset();
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 4);
      case (sel)
        0: ra = 32'h0;
        1: ra = 32'h4;
        2: ra = {$urandom_range(0, 3) == 0 ? 30'h0 : 30'h2, 2'($urandom_range(0, 3))};
        3: ra = {$urandom} & 32'h0000_00FC;
        default: ra = $urandom;
      endcase
      do_req(ra, 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 7) == 0);
    end

    // Saturation of the violation counter.
    if (!m_locked) pulse_lock();
    for (int n = 0; n < 300; n++) begin
      do_req(32'h0, 1'b1, $urandom, 1'b0);
    end
    check("sat_count", viol_count, 8'hFF);

    // Reset during CHECK aborts the request with no strobe and no response.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h10;
    bus.req_we    = 1'b1;
    bus.req_wd    = 32'hA5A5_A5A5;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    reset         = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    check("midrst_req_ready", bus.req_ready, 1'b1);
    check("midrst_we", bus.we, 1'b0);
    check("midrst_rsp_valid", bus.rsp_valid, 1'b0);
    check_status("midrst");
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("midrst_no_rsp", bus.rsp_valid, 1'b0);
      check("midrst_no_we", bus.we, 1'b0);
    end
    do_req(32'h0, 1'b1, 32'h0BAD_F00D, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/key_write_guard.md
Name: key_write_guard

Overview:
- Request-side gatekeeper that sits directly upstream of the key-storage memory and drives its address/we/wd inputs.
- Accepts bus read/write requests over a valid/ready handshake and forwards them to memory. Writes to the protected key region are blocked once the region is locked.
- Reports a per-request error response and keeps a saturating violation counter plus a sticky violation flag for the security monitor.

Parameters:
- ADDR_W, 32, request/memory address width (byte address; word index = addr[ADDR_W-1:2])
- DATA_W, 32, write-data width
- PROT_WORDS, 1, protected word indices are 0 .. PROT_WORDS-1 (index 0 holds the key)
- VCNT_W, 8, violation counter width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low (0 = reset)
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_addr  in  ADDR_W  byte address
- req_we  in  1  1 = write, 0 = read
- req_wd  in  DATA_W  write data
- lock_set  in  1  one-cycle pulse; locks the protected region
- address  out  ADDR_W  to memory address
- we  out  1  to memory write enable
- wd  out  DATA_W  to memory write data
- rsp_valid  out  1  one-cycle response strobe
- rsp_err  out  1  response is an error; qualified by rsp_valid
- locked  out  1  protected region is locked
- viol_count  out  VCNT_W  number of denied requests, saturating
- viol_sticky  out  1  set on the first denial, held until reset

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE, req_ready=1
  - address=0, we=0, wd=0
  - rsp_valid=0, rsp_err=0
  - locked=0, viol_count=0, viol_sticky=0
  - Reset mid-transaction aborts it. No memory write is issued and no response is produced.
- State machine: IDLE -> CHECK -> (ISSUE | DENY) -> IDLE. All outputs are registered.
- IDLE:
  - req_ready=1.
  - When req_valid&&req_ready, capture addr/we/wd and go to CHECK.
- CHECK:
  - req_ready=0.
  - prot = (addr[ADDR_W-1:2] < PROT_WORDS).
  - misaligned = (addr[1:0] != 0).
  - lock_eff = locked || lock_set. A lock pulse arriving in the CHECK cycle already applies.
  - deny = misaligned || (we && prot && lock_eff).
  - deny=1 -> DENY; deny=0 -> ISSUE.
- ISSUE (one cycle):
  - address = captured addr, we = captured we, wd = captured wd.
  - rsp_valid=1, rsp_err=0. Next state IDLE.
- DENY (one cycle):
  - we=0; address and wd keep their previous values, so denied data never reaches memory.
  - rsp_valid=1, rsp_err=1.
  - viol_count += 1, saturating at all-ones.
  - viol_sticky=1. Next state IDLE.
- Outside ISSUE, we=0 and address/wd hold their values. rsp_valid is high only in ISSUE or DENY.
- Latency and throughput:
  - Request accepted at edge T.
  - Memory strobe or response visible after edge T+2.
  - Next accept possible at edge T+3, so one request per 3 cycles.
- Reads are always forwarded, including reads of protected words. Read data is returned by the memory, not by this block.
- Unlocked writes to protected words are forwarded (boot-time key provisioning).
- locked:
  - Set on any cycle with lock_set=1.
  - Cleared only by reset. There is no unlock path.
- Requests with req_valid=1 outside IDLE are not accepted; the requester must hold them stable.
- The violation counter at all-ones stays at all-ones and viol_sticky stays 1.

Decomposition:
- Shared package key_guard_pkg:
  - state enum {IDLE, CHECK, ISSUE, DENY}
  - KEY_WORD_IDX = 0
  - default PROT_WORDS
- One natural sub-module: key_guard_policy.
  - Combinational; inputs addr, we, lock_eff; output deny.
  - Reusable by the read-side checker.
- Counter and FSM stay in the top module.

Test Plan:
- Unlocked provisioning: req addr=0x0, we=1, wd=0x1035_9987 with locked=0 -> after T+2: we=1, address=0x0, wd=0x1035_9987, rsp_valid=1, rsp_err=0.
- Locked key write: lock_set pulse, then req addr=0x0, we=1, wd=0xDEAD_BEEF -> we stays 0, wd unchanged, rsp_err=1, viol_count=1, viol_sticky=1.
- Same-cycle lock: req addr=0x0 write, with lock_set asserted during the CHECK cycle -> DENY, rsp_err=1.
- Non-protected write and key read while locked:
  - addr=0x8, we=1, wd=0x55 -> forwarded with rsp_err=0.
  - addr=0x0, we=0 -> forwarded with we=0, rsp_err=0.
- Misaligned address and saturation:
  - addr=0x6, we=0 -> rsp_err=1.
  - 300 locked key writes with VCNT_W=8 -> viol_count=255.
- Reset mid-operation: reset=0 during CHECK -> next cycle state=IDLE, we=0, rsp_valid=0, locked=0, viol_count=0, req_ready=1.
